// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with a one-entry holding register.
//
// The rx line is synchronized by two flops; every decision uses the synchronized
// copy (rx_s). A start bit is confirmed at its midpoint. Each data bit and the
// stop bit are then sampled one bit period apart, so every sample lands near the
// centre of its bit. A good byte moves into the holding register (rx_data /
// rx_valid). The consumer empties that register with a valid/ready handshake.
// Reception never waits for the consumer. If a byte completes while the register
// is still full, the byte is dropped and the sticky overrun flag is set.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   rx         asynchronous serial input, idle high, LSB first
//   rx_data    received byte, stable while rx_valid=1
//   rx_valid   holding register full
//   rx_ready   consumer takes the byte on an edge where rx_valid=1 and rx_ready=1
//   frame_err  one-cycle pulse after a stop bit sampled low
//   overrun    sticky: a good byte was dropped; cleared only by reset
//   busy       receiver is in any state other than IDLE
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             rx_meta_reg, rx_s_reg;
  logic [7:0]       rx_data_reg;
  logic             rx_valid_reg;
  logic             frame_err_reg;
  logic             overrun_reg;

  // Strobes decoded from the state/counter in the output process.
  logic bit_sample;
  logic stop_good;
  logic stop_bad;
  logic load;
  logic drop;

  // The synchronizer resets to the idle line level, so leaving reset
  // cannot look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (!rx_s_reg) state_next = S_START;
      end
      S_START: begin
        // A start bit that is high again at its midpoint is only a glitch.
        if (cnt_reg == HALF_LAST) state_next = rx_s_reg ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_reg == BIT_LAST && bit_idx_reg == 3'd7) state_next = S_STOP;
      end
      S_STOP: begin
        if (cnt_reg == BIT_LAST) state_next = rx_s_reg ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        // A break (line held low) must end before the next start is looked for.
        if (rx_s_reg) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs and strobes.
  always_comb begin
    busy       = (state_reg != S_IDLE);
    bit_sample = (state_reg == S_DATA) && (cnt_reg == BIT_LAST);
    stop_good  = (state_reg == S_STOP) && (cnt_reg == BIT_LAST) && rx_s_reg;
    stop_bad   = (state_reg == S_STOP) && (cnt_reg == BIT_LAST) && !rx_s_reg;
  end

  // The bit counter restarts on every state change. Inside DATA it also wraps
  // at each sample point. It stays at zero while waiting in IDLE or WAIT_HIGH.
  always_comb begin
    cnt_next = '0;
    if (state_next == state_reg) begin
      if (state_reg == S_START || state_reg == S_DATA || state_reg == S_STOP) begin
        cnt_next = (cnt_reg == BIT_LAST) ? '0 : cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bit_idx_next = bit_idx_reg;
    if (state_reg == S_START) begin
      bit_idx_next = 3'd0;
    end else if (bit_sample) begin
      bit_idx_next = bit_idx_reg + 3'd1;
    end
  end

  // Each data bit has its own capture mux, selected by the bit index.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bits
    assign shift_next[gi] = (bit_sample && bit_idx_reg == 3'(gi)) ? rx_s_reg : shift_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
    end else begin
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  // A register that is being emptied on this edge counts as free. This lets a
  // new byte load on the same edge as a consume without an overrun.
  assign load = stop_good && (!rx_valid_reg || rx_ready);
  assign drop = stop_good && rx_valid_reg && !rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (load) begin
        rx_data_reg  <= shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
      if (drop) overrun_reg <= 1'b1;
      frame_err_reg <= stop_bad;
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule
